// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the LCD digit writer.
//   - lcd_state_t  : top-level sequencing states
//   - xfer_phase_t : phases of one bus write in lcd_bus_xfer
//   - HD44780 command constants
//   - init_cmd()       : n-th command of the power-on initialisation
//   - digit_to_ascii() : hex digit 0..15 to '0'..'9','A'..'F'
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_INIT_SEQ,
        ST_IDLE,
        ST_SET_ADDR,
        ST_WRITE_CHAR
    } lcd_state_t;

    typedef enum logic [1:0] {
        XF_IDLE,
        XF_SETUP,
        XF_PULSE,
        XF_WAIT
    } xfer_phase_t;

    localparam logic [7:0] LCD_FUNC_SET  = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_ENTRY     = 8'h06;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_SET_DDRAM = 8'h80;

    // Power-on command order: 8-bit/2-line, display on, auto-increment, clear.
    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_ENTRY;
            default: return LCD_CLEAR;
        endcase
    endfunction

    function automatic logic [7:0] digit_to_ascii(input logic [3:0] v);
        if (v < 4'd10)
            return 8'h30 + {4'h0, v};
        else
            return 8'h41 + {4'h0, v - 4'd10};
    endfunction

endpackage

// File: rtl/lcd_bus_xfer.sv
// lcd_bus_xfer: one HD44780 write cycle on the 8-bit parallel bus.
//   SETUP (RS/DATA driven, E low) -> PULSE (E high) -> WAIT (E low, settle).
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_start             : launch a write (accepted when idle or on the done cycle)
//   i_rs, i_data        : register select and data byte, latched on start
//   i_long_wait         : use CLEAR_WAIT_CYC instead of CMD_WAIT_CYC for WAIT
//   o_done              : single-cycle pulse in the last WAIT cycle
//   o_rs, o_e, o_data   : registered LCD bus drivers
module lcd_bus_xfer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC      = 5,
    parameter int E_HIGH_CYC     = 25,
    parameter int CMD_WAIT_CYC   = 4000,
    parameter int CLEAR_WAIT_CYC = 160000,
    parameter int CNT_W          = 18
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    input  logic       i_long_wait,
    output logic       o_done,
    output logic       o_rs,
    output logic       o_e,
    output logic [7:0] o_data
);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(E_HIGH_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_WAIT_CYC - 1);

    xfer_phase_t      r_phase;
    xfer_phase_t      w_phase_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_limit;
    logic             w_last;
    logic             w_accept;
    logic             r_rs;
    logic             r_e;
    logic [7:0]       r_data;
    logic             r_long;

    always_comb begin
        w_limit = '0;
        case (r_phase)
            XF_SETUP: w_limit = SETUP_LAST;
            XF_PULSE: w_limit = PULSE_LAST;
            XF_WAIT:  w_limit = r_long ? CLEAR_LAST : CMD_LAST;
            default:  w_limit = '0;
        endcase
    end

    assign w_last   = (r_cnt == w_limit);
    assign o_done   = (r_phase == XF_WAIT) && w_last;
    // Accepting on the done cycle lets back-to-back writes chain with no gap.
    assign w_accept = i_start && ((r_phase == XF_IDLE) || o_done);

    always_comb begin
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (w_accept) begin
            w_phase_nxt = XF_SETUP;
            w_cnt_nxt   = '0;
        end else begin
            case (r_phase)
                XF_IDLE: w_cnt_nxt = '0;
                XF_SETUP: if (w_last) begin
                    w_phase_nxt = XF_PULSE;
                    w_cnt_nxt   = '0;
                end
                XF_PULSE: if (w_last) begin
                    w_phase_nxt = XF_WAIT;
                    w_cnt_nxt   = '0;
                end
                XF_WAIT: if (w_last) begin
                    w_phase_nxt = XF_IDLE;
                    w_cnt_nxt   = '0;
                end
                default: begin
                    w_phase_nxt = XF_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_phase <= XF_IDLE;
            r_cnt   <= '0;
            r_rs    <= 1'b0;
            r_data  <= 8'h00;
            r_long  <= 1'b0;
            r_e     <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
            // E comes straight from a flop so the strobe is glitch-free.
            r_e     <= (w_phase_nxt == XF_PULSE);
            if (w_accept) begin
                r_rs   <= i_rs;
                r_data <= i_data;
                r_long <= i_long_wait;
            end
        end
    end

    assign o_rs   = r_rs;
    assign o_e    = r_e;
    assign o_data = r_data;

endmodule

// File: rtl/lcd_digit_writer.sv
// lcd_digit_writer: writes hex digits 0..3 to an HD44780 character LCD.
// Holds a 4-entry {value, dirty} buffer, runs the power-on init sequence
// and refreshes dirty positions lowest-index first.
// Ports:
//   sysclk, INIT            : clock, asynchronous active-high reset
//   LCD_Enable, Num, LCD_Num: single-cycle digit update strobe
//   LCD_RS, LCD_RW, LCD_E,
//   LCD_DATA                : LCD parallel bus (write only)
//   Busy                    : not in IDLE
//   Ready                   : in IDLE with nothing pending
module lcd_digit_writer
    import lcd_pkg::*;
#(
    parameter int POWERON_CYC    = 1500000,
    parameter int SETUP_CYC      = 5,
    parameter int E_HIGH_CYC     = 25,
    parameter int CMD_WAIT_CYC   = 4000,
    parameter int CLEAR_WAIT_CYC = 160000,
    parameter int BASE_COL       = 0
) (
    input  logic       sysclk,
    input  logic       INIT,
    input  logic       LCD_Enable,
    input  logic [1:0] Num,
    input  logic [3:0] LCD_Num,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_E,
    output logic [7:0] LCD_DATA,
    output logic       Busy,
    output logic       Ready
);

    localparam int CNT_MAX = (POWERON_CYC > CLEAR_WAIT_CYC) ? POWERON_CYC : CLEAR_WAIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] POWERON_LAST = CNT_W'(POWERON_CYC - 1);

    lcd_state_t       r_state;
    lcd_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_pwr_cnt;
    logic [1:0]       r_init_idx;
    logic [3:0]       r_val [4];
    logic [3:0]       r_dirty;
    logic [3:0]       r_char;
    logic [1:0]       w_sel;
    logic             w_any_dirty;
    logic             w_take;
    logic             w_strobe_ok;
    logic             w_start;
    logic             w_xrs;
    logic [7:0]       w_xdata;
    logic             w_long;
    logic             w_done;

    assign w_any_dirty = |r_dirty;

    // Lowest-index dirty position wins.
    always_comb begin
        w_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_dirty[i]) w_sel = 2'(i);
        end
    end

    // Strobes are dropped until the display has been initialised.
    assign w_strobe_ok = LCD_Enable &&
                         (r_state != ST_PWR_WAIT) && (r_state != ST_INIT_SEQ);

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_xrs       = 1'b0;
        w_xdata     = 8'h00;
        w_take      = 1'b0;
        case (r_state)
            ST_PWR_WAIT: if (r_pwr_cnt == POWERON_LAST) begin
                w_start     = 1'b1;
                w_xdata     = init_cmd(2'd0);
                w_state_nxt = ST_INIT_SEQ;
            end
            ST_INIT_SEQ: if (w_done) begin
                if (r_init_idx == 2'd3) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_start = 1'b1;
                    w_xdata = init_cmd(r_init_idx + 2'd1);
                end
            end
            ST_IDLE: if (w_any_dirty) begin
                w_take      = 1'b1;
                w_start     = 1'b1;
                w_xdata     = LCD_SET_DDRAM | 8'(BASE_COL + int'(w_sel));
                w_state_nxt = ST_SET_ADDR;
            end
            ST_SET_ADDR: if (w_done) begin
                w_start     = 1'b1;
                w_xrs       = 1'b1;
                w_xdata     = digit_to_ascii(r_char);
                w_state_nxt = ST_WRITE_CHAR;
            end
            ST_WRITE_CHAR: if (w_done) begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_PWR_WAIT;
        endcase
    end

    // Only the clear command needs the long settle time.
    assign w_long = !w_xrs && (w_xdata == LCD_CLEAR);

    always_ff @(posedge sysclk or posedge INIT) begin
        if (INIT) begin
            r_state    <= ST_PWR_WAIT;
            r_pwr_cnt  <= '0;
            r_init_idx <= 2'd0;
            r_dirty    <= 4'h0;
            r_char     <= 4'h0;
            for (int i = 0; i < 4; i++) r_val[i] <= 4'h0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_PWR_WAIT) && (r_pwr_cnt != POWERON_LAST))
                r_pwr_cnt <= r_pwr_cnt + 1'b1;
            if ((r_state == ST_INIT_SEQ) && w_done)
                r_init_idx <= r_init_idx + 2'd1;
            if (w_take) begin
                r_dirty[w_sel] <= 1'b0;
                r_char         <= r_val[w_sel];
            end
            // Placed after the clear so a same-cycle strobe keeps the entry dirty.
            if (w_strobe_ok) begin
                r_dirty[Num] <= 1'b1;
                r_val[Num]   <= LCD_Num;
            end
        end
    end

    lcd_bus_xfer #(
        .SETUP_CYC      (SETUP_CYC),
        .E_HIGH_CYC     (E_HIGH_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC),
        .CNT_W          (CNT_W)
    ) u_xfer (
        .i_clk       (sysclk),
        .i_rst       (INIT),
        .i_start     (w_start),
        .i_rs        (w_xrs),
        .i_data      (w_xdata),
        .i_long_wait (w_long),
        .o_done      (w_done),
        .o_rs        (LCD_RS),
        .o_e         (LCD_E),
        .o_data      (LCD_DATA)
    );

    assign LCD_RW = 1'b0;
    assign Busy   = (r_state != ST_IDLE);
    assign Ready  = (r_state == ST_IDLE) && !w_any_dirty;

endmodule
